// File: rtl/tag_snoop_sequencer_pkg.sv
// Shared types for the tag-RAM port-B snoop sequencer: entry/request layouts
// at the default geometry and the sequencer state encoding.
package tag_snoop_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_LINES = 512;
  localparam int unsigned DEF_LW    = $clog2(DEF_LINES);

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-2:0] tag;
  } dtag_entry_t;

  typedef struct packed {
    logic [DEF_LW-1:0]    line;
    logic [DEF_WIDTH-2:0] tag;
  } snoop_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_WR
  } tag_seq_state_t;

endpackage

// File: rtl/tag_snoop_sequencer_snoop_fifo.sv
// Generic synchronous FIFO holding queued snoop requests; registered occupancy
// count drives full/empty so the ready path carries no push/pop logic.
module snoop_fifo
  import tag_snoop_sequencer_pkg::*;
#(
  parameter type         T     = snoop_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int unsigned PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tag_snoop_sequencer.sv
// Port-B owner of the dual-port tag RAM: arbitrates local fill/update writes
// against queued remote snoops sequenced as read -> compare -> invalidate.
module tag_snoop_sequencer
  import tag_snoop_sequencer_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned LINES      = 512,
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned MAX_DEFER  = 8,
  localparam int unsigned LW         = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snp_valid,
  output logic             snp_ready,
  input  logic [LW-1:0]    snp_line,
  input  logic [WIDTH-2:0] snp_tag,
  output logic             snp_done,
  output logic             snp_hit,
  input  logic             loc_req,
  input  logic [LW-1:0]    loc_line,
  input  logic [WIDTH-1:0] loc_data,
  output logic             loc_gnt,
  output logic             tb_en_b,
  output logic             tb_wen_b,
  output logic [LW-1:0]    tb_addr_b,
  output logic [WIDTH-1:0] tb_din_b,
  input  logic [WIDTH-1:0] tb_dout_b,
  output logic             busy
);

  localparam int unsigned DW = $clog2(MAX_DEFER + 1);

  typedef struct packed {
    logic [LW-1:0]    line;
    logic [WIDTH-2:0] tag;
  } req_t;

  tag_seq_state_t state, state_nxt;
  logic [DW-1:0]  defer_cnt;
  logic           defer_inc;
  logic           defer_clr;
  logic           defer_ok;

  req_t push_req;
  req_t head;
  logic q_empty;
  logic q_full;
  logic q_push;
  logic q_pop;
  logic tag_hit;

  assign push_req  = '{line: snp_line, tag: snp_tag};
  assign snp_ready = ~q_full;
  assign q_push    = snp_valid & ~q_full;
  assign busy      = ~q_empty | (state != ST_IDLE);
  assign defer_ok  = (defer_cnt < DW'(MAX_DEFER));
  assign tag_hit   = tb_dout_b[WIDTH-1] & (tb_dout_b[WIDTH-2:0] == head.tag);

  snoop_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (q_push),
    .din   (push_req),
    .pop   (q_pop),
    .head  (head),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      defer_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (defer_clr) begin
        defer_cnt <= '0;
      end else if (defer_inc && defer_ok) begin
        defer_cnt <= defer_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    defer_inc = 1'b0;
    defer_clr = 1'b0;
    q_pop     = 1'b0;
    snp_done  = 1'b0;
    snp_hit   = 1'b0;
    loc_gnt   = 1'b0;
    tb_en_b   = 1'b0;
    tb_wen_b  = 1'b0;
    tb_addr_b = '0;
    tb_din_b  = '0;
    case (state)
      ST_IDLE: begin
        // Local writes win IDLE until a waiting snoop has lost MAX_DEFER times.
        if (loc_req && (q_empty || defer_ok)) begin
          tb_en_b   = 1'b1;
          tb_wen_b  = 1'b1;
          tb_addr_b = loc_line;
          tb_din_b  = loc_data;
          loc_gnt   = 1'b1;
          defer_inc = ~q_empty;
        end else if (!q_empty) begin
          tb_en_b   = 1'b1;
          tb_addr_b = head.line;
          defer_clr = 1'b1;
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        state_nxt = ST_CMP;
      end
      ST_CMP: begin
        if (tag_hit) begin
          tb_en_b   = 1'b1;
          tb_wen_b  = 1'b1;
          tb_addr_b = head.line;
          tb_din_b  = {1'b0, head.tag};
          state_nxt = ST_WR;
        end else begin
          q_pop     = 1'b1;
          snp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WR: begin
        q_pop     = 1'b1;
        snp_done  = 1'b1;
        snp_hit   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tag_snoop_sequencer.sv
// Directed bench for tag_snoop_sequencer with a behavioural tag RAM on port B
// and a scoreboard of expected snoop outcomes in issue order.
module tb_tag_snoop_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LINES = 512;
  localparam int unsigned LW    = 9;

  logic             clk;
  logic             rst;
  logic             snp_valid;
  logic             snp_ready;
  logic [LW-1:0]    snp_line;
  logic [WIDTH-2:0] snp_tag;
  logic             snp_done;
  logic             snp_hit;
  logic             loc_req;
  logic [LW-1:0]    loc_line;
  logic [WIDTH-1:0] loc_data;
  logic             loc_gnt;
  logic             tb_en_b;
  logic             tb_wen_b;
  logic [LW-1:0]    tb_addr_b;
  logic [WIDTH-1:0] tb_din_b;
  logic [WIDTH-1:0] tb_dout_b;
  logic             busy;

  logic [WIDTH-1:0] ram [LINES];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rd_cnt      = 0;
  int rd_cyc      = 0;
  int snp_wr_cnt  = 0;
  int gnt_cnt     = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  bit sb [$];

  tag_snoop_sequencer #(
    .WIDTH      (WIDTH),
    .LINES      (LINES),
    .FIFO_DEPTH (4),
    .MAX_DEFER  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .snp_valid (snp_valid),
    .snp_ready (snp_ready),
    .snp_line  (snp_line),
    .snp_tag   (snp_tag),
    .snp_done  (snp_done),
    .snp_hit   (snp_hit),
    .loc_req   (loc_req),
    .loc_line  (loc_line),
    .loc_data  (loc_data),
    .loc_gnt   (loc_gnt),
    .tb_en_b   (tb_en_b),
    .tb_wen_b  (tb_wen_b),
    .tb_addr_b (tb_addr_b),
    .tb_din_b  (tb_din_b),
    .tb_dout_b (tb_dout_b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM; read data holds until the next read.
  always @(posedge clk) begin
    if (tb_en_b) begin
      if (tb_wen_b) ram[tb_addr_b] <= tb_din_b;
      else          tb_dout_b      <= ram[tb_addr_b];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (tb_en_b && !tb_wen_b) begin
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (tb_en_b && tb_wen_b && !loc_gnt) snp_wr_cnt++;
      if (loc_gnt) begin
        gnt_cnt++;
        chk("loc_wr_addr", 32'(tb_addr_b), 32'(loc_line));
        chk("loc_wr_data", tb_din_b, loc_data);
      end
      if (snp_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("snp_hit", 32'(snp_hit), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic loc_write(input logic [LW-1:0] l, input logic [WIDTH-1:0] d);
    int n;
    loc_req  = 1'b1;
    loc_line = l;
    loc_data = d;
    #1;
    n = 0;
    while (!loc_gnt && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("loc_gnt_timeout", 32'(n >= 100), 32'd0);
    @(posedge clk); #1;
    loc_req = 1'b0;
  endtask

  task automatic snoop(input logic [LW-1:0] l, input logic [WIDTH-2:0] t, input bit exp_hit,
                       output int push_cyc);
    int n;
    snp_valid = 1'b1;
    snp_line  = l;
    snp_tag   = t;
    n = 0;
    while (!snp_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("snp_ready_timeout", 32'(n >= 300), 32'd0);
    if (n < 300) begin
      sb.push_back(exp_hit);
      @(posedge clk); #1;
    end
    push_cyc  = cyc;
    snp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size() != 0), 32'd0);
  endtask

  initial begin
    int pc, r0, w0, g0, d0, n;
    rst = 1'b0; snp_valid = 1'b0; snp_line = '0; snp_tag = '0;
    loc_req = 1'b0; loc_line = '0; loc_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_snp_ready", 32'(snp_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_snp_done",  32'(snp_done),  32'd0);
    chk("rst_snp_hit",   32'(snp_hit),   32'd0);
    chk("rst_loc_gnt",   32'(loc_gnt),   32'd0);
    chk("rst_en",        32'(tb_en_b),   32'd0);
    chk("rst_wen",       32'(tb_wen_b),  32'd0);
    chk("rst_addr",      32'(tb_addr_b), 32'd0);
    chk("rst_din",       tb_din_b,       32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Preload through the local write path.
    loc_write(9'd5,  32'h8000_0100);
    loc_write(9'd7,  32'h8000_002A);
    loc_write(9'd3,  32'h0000_002A);
    loc_write(9'd20, 32'h8000_0055);
    loc_write(9'd10, 32'h8000_0A0A);
    loc_write(9'd11, 32'h8000_0B0B);
    loc_write(9'd12, 32'h8000_0C0C);
    loc_write(9'd13, 32'h0000_0D0D);
    loc_write(9'd14, 32'h8000_0E0E);
    loc_write(9'd30, 32'h8000_0030);
    chk("preload_5", ram[5], 32'h8000_0100);

    // Miss on valid entry with different tag.
    r0 = rd_cnt; w0 = snp_wr_cnt;
    snoop(9'd5, 31'h200, 1'b0, pc);
    drain();
    chk("miss_latency", 32'(done_cyc - pc), 32'd2);
    chk("miss_reads",   32'(rd_cnt - r0),    32'd1);
    chk("miss_writes",  32'(snp_wr_cnt - w0), 32'd0);
    chk("miss_ram5",    ram[5], 32'h8000_0100);

    // Hit invalidates the entry.
    w0 = snp_wr_cnt;
    snoop(9'd7, 31'h2A, 1'b1, pc);
    drain();
    chk("hit_latency", 32'(done_cyc - pc), 32'd3);
    chk("hit_writes",  32'(snp_wr_cnt - w0), 32'd1);
    chk("hit_ram7",    ram[7], 32'h0000_002A);

    // Matching tag on an invalid entry is a miss.
    w0 = snp_wr_cnt;
    snoop(9'd3, 31'h2A, 1'b0, pc);
    drain();
    chk("inv_writes", 32'(snp_wr_cnt - w0), 32'd0);
    chk("inv_ram3",   ram[3], 32'h0000_002A);

    // Fill the queue while local traffic holds the port.
    w0 = snp_wr_cnt; d0 = done_cnt;
    loc_req = 1'b1; loc_line = 9'd100; loc_data = 32'h0000_1234;
    snoop(9'd10, 31'h0A0A, 1'b1, pc);
    snoop(9'd11, 31'h0111, 1'b0, pc);
    snoop(9'd12, 31'h0C0C, 1'b1, pc);
    snoop(9'd13, 31'h0D0D, 1'b0, pc);
    chk("full_ready", 32'(snp_ready), 32'd0);
    chk("full_busy",  32'(busy),      32'd1);
    snoop(9'd14, 31'h0E0E, 1'b1, pc);
    chk("fifth_after_pop", 32'(done_cnt - d0), 32'd1);
    loc_req = 1'b0;
    drain();
    chk("full_done_cnt", 32'(done_cnt - d0),   32'd5);
    chk("full_writes",   32'(snp_wr_cnt - w0), 32'd3);
    chk("full_ram14",    ram[14], 32'h0000_0E0E);
    chk("full_ram13",    ram[13], 32'h0000_0D0D);

    // Starvation bound with a stuck local requester.
    loc_req = 1'b1; loc_line = 9'd101; loc_data = 32'h0000_5678;
    @(posedge clk); #1;
    snoop(9'd30, 31'h31, 1'b0, pc);
    g0 = gnt_cnt; r0 = rd_cnt;
    n = 0;
    while (rd_cnt == r0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("starve_rd_timeout", 32'(n >= 50), 32'd0);
    chk("starve_gnts", 32'(gnt_cnt - g0), 32'd8);
    drain();
    chk("starve_blocked", 32'(gnt_cnt - g0), 32'd8);
    chk("starve_resume",  32'(loc_gnt), 32'd1);
    @(posedge clk); #1;
    loc_req = 1'b0;
    @(posedge clk); #1;

    // Reset mid-snoop with three queued.
    snoop(9'd20, 31'h55, 1'b1, pc);
    snoop(9'd21, 31'h21, 1'b0, pc);
    snoop(9'd22, 31'h22, 1'b0, pc);
    d0 = done_cnt;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_ready", 32'(snp_ready), 32'd1);
    chk("mid_rst_done",  32'(snp_done),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_busy",    32'(busy), 32'd0);
    chk("post_rst_ram20",   ram[20], 32'h8000_0055);
    snoop(9'd20, 31'h55, 1'b1, pc);
    drain();
    chk("post_rst_latency", 32'(done_cyc - pc), 32'd3);
    chk("post_rst_inval",   ram[20], 32'h0000_0055);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
